// File: rtl/joy_event_pkg.sv
// Shared types and helpers for the joystick event queue.
// Event word layout: {joy, pressed, bit_idx[3:0]}.
package joy_event_pkg;

   localparam int unsigned EV_W       = 6;
   localparam int unsigned EV_JOY     = 5;
   localparam int unsigned EV_PRESS   = 4;
   localparam int unsigned EV_IDX_MSB = 3;
   localparam int unsigned EV_IDX_LSB = 0;
   localparam int unsigned NUM_BTNS   = 32;
   localparam int unsigned BTN_IDX_W  = 5;

   // Event payload as carried on the consumer bus
   typedef struct packed {
      logic       joy;     // 0 = player 1, 1 = player 2
      logic       press;   // 1 = press, 0 = release
      logic [3:0] idx;     // bit index within the player word
   } ev_t;

   function automatic ev_t pack_event(input logic joy, input logic press, input logic [3:0] idx);
      ev_t e;
      e.joy   = joy;
      e.press = press;
      e.idx   = idx;
      return e;
   endfunction

endpackage

// File: rtl/joy_event_queue_if.sv
// Event stream handshake between the queue (master) and the test-screen consumer (slave).
//  ev_valid : head of queue holds an event
//  ev_ready : consumer accepts the head this cycle
//  ev_data  : event payload, meaningful only while ev_valid
interface joy_event_queue_if;
   import joy_event_pkg::*;

   logic ev_valid;
   logic ev_ready;
   ev_t  ev_data;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/joy_event_fifo.sv
// Small synchronous FIFO with registered full/empty and show-ahead output.
//  clk, reset : clock, asynchronous active-high reset
//  push, din  : write request and data (ignored while full)
//  pop        : read request (ignored while empty)
//  dout       : current head entry
//  full/empty : registered occupancy flags
module joy_event_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic [CW-1:0]               count;
   logic [CW-1:0]               count_next;
   logic                        push_ok;
   logic                        pop_ok;

   // Full/empty come from registers, so a same-cycle pop never frees room for a push
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Occupancy after this cycle's accepted push/pop
   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count - CW'(1);
      end
   end

   // Storage, pointers (wrap naturally at power-of-two depth) and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == CW'(0));
      end
   end

endmodule

// File: rtl/joy_event_queue.sv
// Debounces the two 16-bit joystick button words and queues one event per
// debounced press/release for the test-screen logic.
//  clk, reset           : clock, asynchronous active-high reset
//  joystick1/joystick2  : raw button words, 1 = pressed
//  joy1_db/joy2_db      : debounced button words
//  ev                   : event stream (valid/ready/data)
//  ev_overrun           : sticky, set when an event had to wait for FIFO room
module joy_event_queue
   import joy_event_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned DEB_SAMPLES = 3,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              joystick1,
   input  logic [15:0]              joystick2,
   output logic [15:0]              joy1_db,
   output logic [15:0]              joy2_db,
   joy_event_queue_if.master        ev,
   output logic                     ev_overrun
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]                        presc;
   logic                                    tick_c;
   logic [NUM_BTNS-1:0]                     raw_c;
   logic [NUM_BTNS-1:0][DEB_SAMPLES-1:0]    hist;
   logic [NUM_BTNS-1:0][DEB_SAMPLES-1:0]    hist_next_c;
   logic [NUM_BTNS-1:0]                     flip_c;
   logic [NUM_BTNS-1:0]                     stable;
   logic [NUM_BTNS-1:0]                     chg;
   logic [NUM_BTNS-1:0]                     pending;
   logic [NUM_BTNS-1:0]                     emit_mask_c;
   logic [BTN_IDX_W-1:0]                    sel_idx_c;
   logic                                    push_c;
   logic                                    pop_c;
   ev_t                                     din_c;
   logic                                    fifo_full;
   logic                                    fifo_empty;
   logic [EV_W-1:0]                         fifo_dout;

   assign raw_c   = {joystick2, joystick1};
   assign tick_c  = (presc == CNT_W'(TICK_DIV - 1));
   assign joy1_db = stable[15:0];
   assign joy2_db = stable[31:16];

   // Sample-tick prescaler
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   // A bit flips once the full history, including this tick's sample, agrees on the opposite level
   always_comb begin
      hist_next_c = hist;
      flip_c      = '0;
      for (int b = 0; b < int'(NUM_BTNS); b++) begin
         hist_next_c[b] = {hist[b][DEB_SAMPLES-2:0], raw_c[b]};
         if (tick_c) begin
            flip_c[b] = ( (&hist_next_c[b]) & ~stable[b]) |
                        (~(|hist_next_c[b]) &  stable[b]);
         end
      end
   end

   // Debounce state; the first history stage doubles as the input synchroniser
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist   <= '0;
         stable <= '0;
         chg    <= '0;
      end else begin
         if (tick_c) begin
            hist <= hist_next_c;
         end
         stable <= stable ^ flip_c;
         chg    <= flip_c;
      end
   end

   // Lowest pending index wins: P1 bit0 first, P2 bit15 last
   always_comb begin
      sel_idx_c = '0;
      for (int i = int'(NUM_BTNS) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_idx_c = BTN_IDX_W'(i);
         end
      end
   end

   // Emit one event per cycle when there is room; the event reports the current level
   always_comb begin
      push_c      = (|pending) & ~fifo_full;
      emit_mask_c = '0;
      din_c       = pack_event(sel_idx_c[4], stable[sel_idx_c], sel_idx_c[3:0]);
      if (push_c) begin
         emit_mask_c = NUM_BTNS'(1) << sel_idx_c;
      end
   end

   // Double change before emission cancels out; a change coinciding with emission re-arms the bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending    <= '0;
         ev_overrun <= 1'b0;
      end else begin
         pending <= (pending & ~emit_mask_c) ^ chg;
         if ((|pending) && fifo_full) begin
            ev_overrun <= 1'b1;
         end
      end
   end

   assign pop_c       = ~fifo_empty & ev.ev_ready;
   assign ev.ev_valid = ~fifo_empty;
   assign ev.ev_data  = ev_t'(fifo_dout);

   joy_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .din   (EV_W'(din_c)),
      .full  (fifo_full),
      .pop   (pop_c),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

endmodule
